dpi_stream_sequencer: RTL and testbench

//  Sequences a bank of per-category regex matcher wrappers (NUM_MATCH instances) for one packet at a time.

---
 rtl/dpi_stream_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// dpi_stream_sequencer
//
// Purpose
//   Walks one packet at a time from the ingress FIFO through a bank of
//   NUM_MATCH regex matcher wrappers. For each packet it:
//     - looks up whether the stream ID has been seen before,
//     - pulses load_state so every matcher restores its per-stream state
//       (or starts from state 0 when new_stream_id=1),
//     - streams the packet bytes on char_in/char_in_vld,
//     - waits for the matcher pipeline to drain, then pulses eop,
//     - captures fired & enable and offers it on the result port.
//   Exactly one packet is in flight. Ingress is back-pressured outside the
//   streaming window.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   pkt_*           ingress byte stream (valid/ready); pkt_sid/pkt_en are
//                   qualified by pkt_sop
//   seen_clr        clears the seen-stream table (acted on in IDLE only)
//   load_state      1-cycle pulse to matchers at packet start
//   new_stream_id   1 when the stream ID was not in the seen table
//   stream_id       stream ID to matchers, stable from load_state to eop
//   char_in(_vld)   byte stream to matchers
//   eop             1-cycle pulse: matchers commit count/state
//   enable          per-category enable, stable from load_state to eop
//   fired           per-matcher match flags, sampled in the eop cycle
//   res_*           result handshake: res_sid, res_fired held until res_rdy
// -----------------------------------------------------------------------------
module dpi_stream_sequencer #(
  parameter int NUM_MATCH = 8,
  parameter int STREAM_W  = 6,
  parameter int LOAD_LAT  = 1,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_vld,
  output logic                 pkt_rdy,
  input  logic [7:0]           pkt_data,
  input  logic                 pkt_sop,
  input  logic                 pkt_eop,
  input  logic [STREAM_W-1:0]  pkt_sid,
  input  logic [NUM_MATCH-1:0] pkt_en,
  input  logic                 seen_clr,
  output logic                 load_state,
  output logic                 new_stream_id,
  output logic [STREAM_W-1:0]  stream_id,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_MATCH-1:0] enable,
  input  logic [NUM_MATCH-1:0] fired,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [STREAM_W-1:0]  res_sid,
  output logic [NUM_MATCH-1:0] res_fired
);

  localparam int         DEPTH      = 1 << STREAM_W;
  // Counters hold "cycles still to wait"; zero means the current cycle is the last one.
  localparam logic [7:0] LAT_INIT   = 8'(LOAD_LAT - 1);
  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_EOP    = 3'd5,
    ST_RESULT = 3'd6
  } state_t;

  state_t           state_r;
  logic             rdy_r;        // ingress accept window open
  logic [7:0]       lat_cnt_r;
  logic [7:0]       drain_cnt_r;
  logic [DEPTH-1:0] seen_r;
  logic             drop_s;
  logic             accept_s;

  // A non-sop byte sitting at the FIFO head in IDLE is swallowed in the same
  // cycle, so misframed leftovers cannot wedge the ingress.
  assign drop_s   = rst_n & (state_r == ST_IDLE) & pkt_vld & ~pkt_sop;
  assign accept_s = rdy_r & pkt_vld;
  assign pkt_rdy  = rdy_r | drop_s;

  // Packet sequencing FSM with registered matcher-side and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      rdy_r         <= 1'b0;
      lat_cnt_r     <= 8'd0;
      drain_cnt_r   <= 8'd0;
      seen_r        <= '0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      char_in       <= 8'd0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      enable        <= '0;
      res_vld       <= 1'b0;
      res_sid       <= '0;
      res_fired     <= '0;
    end else begin
      // Single-cycle strobes fall back to zero unless set below.
      load_state  <= 1'b0;
      char_in_vld <= 1'b0;
      eop         <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (seen_clr) begin
            seen_r <= '0;
          end else if (pkt_vld && pkt_sop) begin
            // The sop beat is only peeked here; it is consumed once the
            // accept window opens so that its byte becomes the first char.
            state_r       <= ST_LOAD;
            load_state    <= 1'b1;
            new_stream_id <= ~seen_r[pkt_sid];
            stream_id     <= pkt_sid;
            enable        <= pkt_en;
            lat_cnt_r     <= LAT_INIT;
            // The accept window opens in the last cycle of the load latency,
            // so the first char_in_vld lands exactly LOAD_LAT after load_state.
            rdy_r         <= (LAT_INIT == 8'd0);
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_LOAD, ST_GAP: begin
          if (lat_cnt_r == 8'd0) begin
            state_r <= ST_STREAM;
          end else begin
            state_r   <= ST_GAP;
            lat_cnt_r <= lat_cnt_r - 8'd1;
            rdy_r     <= (lat_cnt_r == 8'd1);
          end
        end

        ST_STREAM: begin
          state_r <= ST_STREAM;
        end

        ST_DRAIN: begin
          if (drain_cnt_r == 8'd0) begin
            state_r <= ST_EOP;
            eop     <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 8'd1;
          end
        end

        ST_EOP: begin
          res_fired         <= fired & enable;
          res_sid           <= stream_id;
          res_vld           <= 1'b1;
          seen_r[stream_id] <= 1'b1;
          state_r           <= ST_RESULT;
        end

        ST_RESULT: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            res_vld <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          rdy_r   <= 1'b0;
        end
      endcase

      // Accepted ingress beats override the state step above: the byte goes
      // out next cycle, and the final beat closes the window and starts the
      // drain count (DRAIN_CYC cycles from the last char_in_vld to eop).
      if (accept_s) begin
        char_in     <= pkt_data;
        char_in_vld <= 1'b1;
        if (pkt_eop) begin
          rdy_r       <= 1'b0;
          drain_cnt_r <= DRAIN_INIT;
          state_r     <= ST_DRAIN;
        end else begin
          rdy_r <= 1'b1;
        end
      end else begin
        char_in <= char_in;
      end
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
module tb_dpi_stream_sequencer;

  localparam int NUM_MATCH = 8;
  localparam int STREAM_W  = 6;
  localparam int LOAD_LAT  = 1;
  localparam int DRAIN_CYC = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 pkt_vld;
  logic                 pkt_rdy;
  logic [7:0]           pkt_data;
  logic                 pkt_sop;
  logic                 pkt_eop;
  logic [STREAM_W-1:0]  pkt_sid;
  logic [NUM_MATCH-1:0] pkt_en;
  logic                 seen_clr;
  logic                 load_state;
  logic                 new_stream_id;
  logic [STREAM_W-1:0]  stream_id;
  logic [7:0]           char_in;
  logic                 char_in_vld;
  logic                 eop;
  logic [NUM_MATCH-1:0] enable;
  logic [NUM_MATCH-1:0] fired;
  logic                 res_vld;
  logic                 res_rdy;
  logic [STREAM_W-1:0]  res_sid;
  logic [NUM_MATCH-1:0] res_fired;

  dpi_stream_sequencer #(
    .NUM_MATCH (NUM_MATCH),
    .STREAM_W  (STREAM_W),
    .LOAD_LAT  (LOAD_LAT),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_vld       (pkt_vld),
    .pkt_rdy       (pkt_rdy),
    .pkt_data      (pkt_data),
    .pkt_sop       (pkt_sop),
    .pkt_eop       (pkt_eop),
    .pkt_sid       (pkt_sid),
    .pkt_en        (pkt_en),
    .seen_clr      (seen_clr),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .enable        (enable),
    .fired         (fired),
    .res_vld       (res_vld),
    .res_rdy       (res_rdy),
    .res_sid       (res_sid),
    .res_fired     (res_fired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packet record: stimulus plus hand-computed expectations.
  typedef struct {
    logic [5:0] sid;
    logic [7:0] en;
    int         len;
    logic [7:0] base;     // bytes are base, base+1, ...
    logic [7:0] gap;      // bit i: one idle cycle after beat i
    logic [7:0] fired;
    int         hold;     // cycles res_rdy stays low after res_vld
    logic       exp_new;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[6];
  vec_t hv;

  int n_pass  = 0;
  int n_total = 0;

  // Monitor state, sampled on the falling edge.
  int         load_cnt = 0;
  int         eop_cnt = 0;
  int         mon_err = 0;
  int         load_cyc = 0;
  int         first_char_cyc = 0;
  int         last_char_cyc = 0;
  int         eop_cyc = 0;
  logic       load_new = 1'b0;
  logic [5:0] load_sid = 6'd0;
  logic [7:0] load_en = 8'd0;
  logic       win = 1'b0;
  logic [7:0] chars[$];

  always @(negedge clk) begin
    if (load_state) begin
      load_cnt++;
      load_cyc = cyc;
      load_new = new_stream_id;
      load_sid = stream_id;
      load_en  = enable;
      win      = 1'b1;
    end
    if (win && (stream_id != load_sid || enable != load_en)) mon_err++;
    if (char_in_vld) begin
      if (chars.size() == 0) first_char_cyc = cyc;
      chars.push_back(char_in);
      last_char_cyc = cyc;
    end
    if (char_in_vld && eop) mon_err++;
    if (eop) begin
      eop_cnt++;
      eop_cyc = cyc;
      win     = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    load_cnt       = 0;
    eop_cnt        = 0;
    mon_err        = 0;
    first_char_cyc = -100;
    last_char_cyc  = -100;
    eop_cyc        = 0;
    win            = 1'b0;
    chars.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctrl"}, 32'({pkt_rdy, load_state, new_stream_id, char_in_vld, eop, res_vld}), 32'd0);
    check({tag, "_data"}, 32'({stream_id, enable, char_in}), 32'd0);
    check({tag, "_res"},  32'({res_sid, res_fired}), 32'd0);
  endtask

  // Drive one packet, collect the result, then check what the monitor saw.
  task automatic run_pkt(input vec_t v, input string tag);
    int acc;
    int got;
    int herr;
    int bad;
    clear_mon();
    fired = v.fired;
    for (int i = 0; i < v.len; i++) begin
      pkt_vld  = 1'b1;
      pkt_data = v.base + 8'(i);
      pkt_sop  = (i == 0);
      pkt_eop  = (i == v.len - 1);
      pkt_sid  = v.sid;
      pkt_en   = v.en;
      acc = 0;
      for (int w = 0; w < 40 && acc == 0; w++) begin
        @(negedge clk);
        acc = int'(pkt_rdy);
        @(posedge clk); #1;
      end
      pkt_vld = 1'b0;
      pkt_sop = 1'b0;
      pkt_eop = 1'b0;
      if (acc == 0) begin
        check({tag, "_ingress"}, 32'(acc), 32'd1);
        break;
      end
      if (v.gap[i % 8]) begin
        @(posedge clk); #1;
      end
    end

    got = 0;
    for (int w = 0; w < 60 && got == 0; w++) begin
      @(negedge clk);
      got = int'(res_vld);
    end
    check({tag, "_res_vld_up"}, 32'(got), 32'd1);
    @(posedge clk); #1;

    // While the result is unconsumed: ingress stays stalled and seen_clr is ignored.
    herr = 0;
    for (int h = 0; h < v.hold; h++) begin
      pkt_vld  = 1'b1;
      pkt_sop  = 1'b1;
      pkt_data = 8'hEE;
      seen_clr = 1'b1;
      @(negedge clk);
      if (!res_vld || pkt_rdy || load_state) herr++;
      @(posedge clk); #1;
    end
    pkt_vld  = 1'b0;
    pkt_sop  = 1'b0;
    seen_clr = 1'b0;
    if (v.hold > 0) check({tag, "_hold"}, 32'(herr), 32'd0);

    res_rdy = 1'b1;
    @(negedge clk);
    check({tag, "_res_sid"},   32'(res_sid), 32'(v.sid));
    check({tag, "_res_fired"}, 32'(res_fired), 32'(v.exp_res));
    @(posedge clk); #1;
    res_rdy = 1'b0;
    @(negedge clk);
    check({tag, "_res_vld_down"}, 32'(res_vld), 32'd0);
    @(posedge clk); #1;

    bad = 0;
    for (int i = 0; i < chars.size(); i++) begin
      if (chars[i] !== v.base + 8'(i)) bad++;
    end
    check({tag, "_load_cnt"},   32'(load_cnt), 32'd1);
    check({tag, "_new_id"},     32'(load_new), 32'(v.exp_new));
    check({tag, "_stream_id"},  32'(load_sid), 32'(v.sid));
    check({tag, "_enable"},     32'(load_en), 32'(v.en));
    check({tag, "_char_cnt"},   32'(chars.size()), 32'(v.len));
    check({tag, "_char_data"},  32'(bad), 32'd0);
    check({tag, "_load_lat"},   32'(first_char_cyc - load_cyc), 32'(LOAD_LAT));
    check({tag, "_drain"},      32'(eop_cyc - last_char_cyc), 32'(DRAIN_CYC));
    check({tag, "_eop_cnt"},    32'(eop_cnt), 32'd1);
    check({tag, "_stable"},     32'(mon_err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int herr;
    //            sid     en     len base   gap    fired  hold new   res
    vecs[0] = '{6'd5,  8'hFF, 3, 8'h61, 8'h00, 8'h00, 0,  1'b1, 8'h00}; // "abc"
    vecs[1] = '{6'd5,  8'hFF, 2, 8'h78, 8'h00, 8'hFF, 0,  1'b0, 8'hFF};
    vecs[2] = '{6'd6,  8'h0F, 4, 8'h10, 8'h05, 8'hA5, 10, 1'b1, 8'h05};
    vecs[3] = '{6'd6,  8'h00, 1, 8'hC3, 8'h00, 8'hFF, 0,  1'b0, 8'h00};
    vecs[4] = '{6'd63, 8'h80, 1, 8'hFE, 8'h00, 8'h80, 0,  1'b1, 8'h80};
    vecs[5] = '{6'd0,  8'h0F, 5, 8'h40, 8'h0F, 8'hF0, 0,  1'b1, 8'h00};

    rst_n    = 1'b0;
    pkt_vld  = 1'b0;
    pkt_data = 8'd0;
    pkt_sop  = 1'b0;
    pkt_eop  = 1'b0;
    pkt_sid  = 6'd0;
    pkt_en   = 8'd0;
    seen_clr = 1'b0;
    fired    = 8'd0;
    res_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      run_pkt(vecs[k], $sformatf("v%0d", k));
    end

    // seen_clr in IDLE: sid 5 becomes new again.
    seen_clr = 1'b1;
    @(posedge clk); #1;
    seen_clr = 1'b0;
    hv = '{6'd5, 8'h3C, 2, 8'h30, 8'h00, 8'h3C, 0, 1'b1, 8'h3C};
    run_pkt(hv, "clr");

    // Stray non-sop bytes in IDLE are consumed and dropped.
    clear_mon();
    herr = 0;
    for (int k = 0; k < 4; k++) begin
      pkt_vld  = 1'b1;
      pkt_sop  = 1'b0;
      pkt_data = 8'hD0 + 8'(k);
      @(negedge clk);
      if (!pkt_rdy) herr++;
      @(posedge clk); #1;
    end
    pkt_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_rdy",   32'(herr), 32'd0);
    check("stray_load",  32'(load_cnt), 32'd0);
    check("stray_chars", 32'(chars.size()), 32'd0);
    hv = '{6'd6, 8'hFF, 3, 8'h20, 8'h02, 8'h11, 0, 1'b1, 8'h11};
    run_pkt(hv, "post_stray");

    // Reset in the middle of a stream: no eop, table cleared.
    clear_mon();
    pkt_sid  = 6'd5;
    pkt_en   = 8'hFF;
    pkt_vld  = 1'b1;
    pkt_sop  = 1'b1;
    pkt_eop  = 1'b0;
    pkt_data = 8'h11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pkt_sop  = 1'b0;
    pkt_data = 8'h22;
    @(posedge clk); #1;
    pkt_vld = 1'b0;
    @(negedge clk);
    check("midrst_streaming", 32'({char_in_vld, char_in}), 32'h122);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_eop", 32'(eop_cnt), 32'd0);
    hv = '{6'd5, 8'h01, 1, 8'h7A, 8'h00, 8'h03, 0, 1'b1, 8'h01};
    run_pkt(hv, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
